// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request feeding a DEPTH-entry queue to decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned fetch addresses in a FAULT state.
module inst_fetch #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h00400020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        en_inst_mem,
  output logic        pc_en,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        id_ready,
  output logic        fetch_fault
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, WAIT, FAULT} state_t;
  localparam logic [31:0] RESET_ADDR = RESET_PC;
  logic fault_n;
`else
  typedef enum logic [1:0] {IDLE, WAIT} state_t;
  localparam logic [31:0] RESET_ADDR = {RESET_PC[31:2], 2'b00};
  logic unused_pc_lo;
  assign unused_pc_lo = ^pc[1:0];
  assign fetch_fault  = 1'b0;
`endif

  state_t          state, state_n;
  logic            discard;
  logic [PW-1:0]   wptr, rptr, rptr_n;
  logic [CW-1:0]   count, count_n;
  logic [31:0]     q_data [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [31:0]     addr_n;
  logic            ack, launch, push, pop;

  // Next-state, handshake qualification and queue bookkeeping
  always_comb begin
    state_n = state;
    addr_n  = mem_addr;
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_n = fetch_fault;
`endif
    ack     = mem_req && mem_ack;
    launch  = (state == IDLE) && en_inst_mem && !flush && (count < CW'(DEPTH));
    push    = ack && !discard && !flush;
    pop     = instr_valid && id_ready && !flush;
    pc_en   = push || flush;
    case (state)
      IDLE: begin
        if (launch) begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (pc[1:0] != 2'b00) begin
            state_n = FAULT;
            fault_n = 1'b1;
          end else begin
            state_n = WAIT;
            addr_n  = pc;
          end
`else
          state_n = WAIT;
          addr_n  = {pc[31:2], 2'b00};
`endif
        end
      end
      WAIT: begin
        if (ack) state_n = IDLE;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT: begin
        if (flush) begin
          state_n = IDLE;
          fault_n = 1'b0;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
    rptr_n  = flush ? '0 : rptr + PW'(pop);
    count_n = flush ? '0 : count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Request, discard, queue storage and registered decode-side head
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req     <= 1'b0;
      mem_addr    <= RESET_ADDR;
      discard     <= 1'b0;
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      mem_req  <= (state_n == WAIT);
      mem_addr <= addr_n;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault <= fault_n;
`endif
      // A flush in WAIT poisons the response still in flight
      if (ack)                          discard <= 1'b0;
      else if (flush && state == WAIT)  discard <= 1'b1;
      if (flush) begin
        wptr <= '0;
      end else if (push) begin
        q_data[wptr] <= mem_rdata;
        q_pc[wptr]   <= mem_addr;
        wptr         <= wptr + PW'(1);
      end
      rptr        <= rptr_n;
      count       <= count_n;
      instr_valid <= (count_n != '0);
      if (count_n != '0) begin
        if (push && wptr == rptr_n) {instr, instr_pc} <= {mem_rdata, mem_addr};
        else                        {instr, instr_pc} <= {q_data[rptr_n], q_pc[rptr_n]};
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; models the PC register that consumes pc_en.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h00400020;

  logic        clk, reset, en_inst_mem, flush, mem_ack, id_ready;
  logic        pc_en, mem_req, instr_valid, fetch_fault;
  logic [31:0] pc, mem_addr, mem_rdata, instr, instr_pc, flush_target;
  int          tests = 0;
  int          fails = 0;
  int          pc_en_cnt = 0;
  int          base;

  inst_fetch #(.DEPTH(2), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .pc(pc), .en_inst_mem(en_inst_mem), .pc_en(pc_en),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .id_ready(id_ready), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register: +4 on pc_en, redirect target when pc_en comes from a flush
  always @(posedge clk or negedge reset) begin
    if (!reset)     pc <= RESET_PC;
    else if (pc_en) pc <= flush ? flush_target : pc + 32'd4;
  end

  always @(posedge clk) if (reset && pc_en) pc_en_cnt <= pc_en_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; en_inst_mem = 1'b0; flush = 1'b0; mem_ack = 1'b0; id_ready = 1'b0;
    mem_rdata = '0; flush_target = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en_inst_mem = 1'b1; flush = 1'b0; mem_ack = 1'b1; id_ready = 1'b1;
    mem_rdata = 32'hFFFFFFFF; flush_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if ({mem_req, pc_en, instr_valid, fetch_fault} !== 4'b0000) begin fails++; $display("FAIL reset_ctrl: got req/pc_en/valid/fault=%b want 0000", {mem_req, pc_en, instr_valid, fetch_fault}); end
    tests++; if (mem_addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", mem_addr, RESET_PC); end
    tests++; if ({instr, instr_pc} !== 64'd0) begin fails++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
  endtask

  task automatic test_basic();
    do_reset();
    id_ready = 1'b1; en_inst_mem = 1'b1; base = pc_en_cnt;
    @(negedge clk);
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL basic_no_early_req: got %b want 0", mem_req); end
    step();
    @(negedge clk);
    tests++; if ({mem_req, pc_en} !== 2'b10 || mem_addr !== 32'h00400020) begin fails++; $display("FAIL basic_launch: got req=%b pc_en=%b addr=%h want 1 0 00400020", mem_req, pc_en, mem_addr); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h20080005; en_inst_mem = 1'b0;
    @(negedge clk);
    tests++; if ({mem_req, pc_en} !== 2'b11) begin fails++; $display("FAIL basic_ack_cycle: got req=%b pc_en=%b want 1 1", mem_req, pc_en); end
    step();
    mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h20080005 || instr_pc !== 32'h00400020) begin fails++; $display("FAIL basic_instr: got v=%b %h @%h want 1 20080005 @00400020", instr_valid, instr, instr_pc); end
    step();
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin fails++; $display("FAIL basic_pop: got v=%b req=%b want 0 0", instr_valid, mem_req); end
    tests++; if (pc_en_cnt - base != 1 || pc !== 32'h00400024) begin fails++; $display("FAIL basic_pc_en: got pulses=%0d pc=%h want 1 00400024", pc_en_cnt - base, pc); end
  endtask

  task automatic test_queue_full();
    int late_req;
    do_reset();
    id_ready = 1'b0; en_inst_mem = 1'b1; base = pc_en_cnt; late_req = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ack = mem_req; mem_rdata = mem_addr ^ 32'hA5A50000;
      @(posedge clk);
      if (i >= 6 && mem_req) late_req++;
      #1;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    tests++; if (pc_en_cnt - base != 2) begin fails++; $display("FAIL full_pushes: got %0d pc_en pulses want 2", pc_en_cnt - base); end
    tests++; if (late_req != 0 || mem_req !== 1'b0) begin fails++; $display("FAIL full_no_req: got %0d late req cycles, req=%b want 0 0", late_req, mem_req); end
    tests++; if (instr_valid !== 1'b1 || instr !== 32'hA5E50020 || instr_pc !== 32'h00400020) begin fails++; $display("FAIL full_head: got v=%b %h @%h want 1 a5e50020 @00400020", instr_valid, instr, instr_pc); end
    step();
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    @(negedge clk);
    tests++; if (mem_req !== 1'b0 || instr !== 32'hA5E50024 || instr_pc !== 32'h00400024) begin fails++; $display("FAIL full_no_bypass: got req=%b %h @%h want 0 a5e50024 @00400024", mem_req, instr, instr_pc); end
    step();
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h00400028) begin fails++; $display("FAIL full_relaunch: got req=%b addr=%h want 1 00400028", mem_req, mem_addr); end
  endtask

  task automatic test_flush_wait();
    do_reset();
    id_ready = 1'b1; en_inst_mem = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h11111111) begin fails++; $display("FAIL fw_first: got v=%b %h want 1 11111111", instr_valid, instr); end
    step();
    flush = 1'b1; flush_target = 32'h00400100; base = pc_en_cnt;
    @(negedge clk);
    tests++; if ({mem_req, pc_en} !== 2'b11 || mem_addr !== 32'h00400024) begin fails++; $display("FAIL fw_flush_cycle: got req=%b pc_en=%b addr=%h want 1 1 00400024", mem_req, pc_en, mem_addr); end
    step();
    flush = 1'b0;
    @(negedge clk);
    tests++; if ({mem_req, pc_en, instr_valid} !== 3'b100 || mem_addr !== 32'h00400024) begin fails++; $display("FAIL fw_hold: got req=%b pc_en=%b v=%b addr=%h want 1 0 0 00400024", mem_req, pc_en, instr_valid, mem_addr); end
    step();
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    tests++; if (pc_en !== 1'b0) begin fails++; $display("FAIL fw_drop_pc_en: got %b want 0", pc_en); end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instr === 32'hDEADBEEF) begin fails++; $display("FAIL fw_dropped: got v=%b req=%b instr=%h want 0 0 not deadbeef", instr_valid, mem_req, instr); end
    step();
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h00400100 || pc_en_cnt - base != 1) begin fails++; $display("FAIL fw_redirect: got req=%b addr=%h pulses=%0d want 1 00400100 1", mem_req, mem_addr, pc_en_cnt - base); end
  endtask

  task automatic test_flush_ack_pop();
    do_reset();
    id_ready = 1'b0; en_inst_mem = 1'b1;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h22222222;
    step();
    mem_ack = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 32'h33333333; flush = 1'b1; flush_target = 32'h00400200;
    id_ready = 1'b1; base = pc_en_cnt;
    @(negedge clk);
    tests++; if ({mem_req, instr_valid, pc_en} !== 3'b111) begin fails++; $display("FAIL fap_setup: got req=%b v=%b pc_en=%b want 1 1 1", mem_req, instr_valid, pc_en); end
    step();
    mem_ack = 1'b0; flush = 1'b0; id_ready = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc_en_cnt - base != 1 || pc !== 32'h00400200) begin fails++; $display("FAIL fap_empty: got v=%b req=%b pulses=%0d pc=%h want 0 0 1 00400200", instr_valid, mem_req, pc_en_cnt - base, pc); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h44444444;
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h00400200 || pc_en !== 1'b1) begin fails++; $display("FAIL fap_next_req: got req=%b addr=%h pc_en=%b want 1 00400200 1", mem_req, mem_addr, pc_en); end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr !== 32'h44444444 || instr_pc !== 32'h00400200) begin fails++; $display("FAIL fap_next_push: got v=%b %h @%h want 1 44444444 @00400200", instr_valid, instr, instr_pc); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    en_inst_mem = 1'b1; id_ready = 1'b1;
    step();
    @(negedge clk);
    tests++; if (mem_req !== 1'b1) begin fails++; $display("FAIL rmw_in_wait: got req=%b want 1", mem_req); end
    #1 reset = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || mem_addr !== RESET_PC) begin fails++; $display("FAIL rmw_async: got req=%b addr=%h want 0 %h", mem_req, mem_addr, RESET_PC); end
    @(posedge clk);
    #1 reset = 1'b1; en_inst_mem = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555; base = pc_en_cnt;
    @(negedge clk);
    tests++; if ({mem_req, pc_en} !== 2'b00) begin fails++; $display("FAIL rmw_late_ack: got req=%b pc_en=%b want 0 0", mem_req, pc_en); end
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b0 || pc_en_cnt != base) begin fails++; $display("FAIL rmw_no_push: got v=%b pulses=%0d want 0 0", instr_valid, pc_en_cnt - base); end
  endtask

  task automatic test_misalign();
    do_reset();
    flush = 1'b1; flush_target = 32'h00400022;
    step();
    flush = 1'b0; en_inst_mem = 1'b1;
    step();
    @(negedge clk);
`ifdef FETCH_MISALIGN_TRAP_EN
    tests++; if ({fetch_fault, mem_req, pc_en} !== 3'b100) begin fails++; $display("FAIL mis_fault: got fault=%b req=%b pc_en=%b want 1 0 0", fetch_fault, mem_req, pc_en); end
    step();
    flush = 1'b1; flush_target = 32'h00400040;
    @(negedge clk);
    tests++; if ({fetch_fault, mem_req} !== 2'b10) begin fails++; $display("FAIL mis_sticky: got fault=%b req=%b want 1 0", fetch_fault, mem_req); end
    step();
    flush = 1'b0;
    @(negedge clk);
    tests++; if ({fetch_fault, mem_req} !== 2'b00) begin fails++; $display("FAIL mis_clear: got fault=%b req=%b want 0 0", fetch_fault, mem_req); end
    step();
    @(negedge clk);
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h00400040) begin fails++; $display("FAIL mis_resume: got req=%b addr=%h want 1 00400040", mem_req, mem_addr); end
`else
    tests++; if ({fetch_fault, mem_req} !== 2'b01 || mem_addr !== 32'h00400020) begin fails++; $display("FAIL mis_align: got fault=%b req=%b addr=%h want 0 1 00400020", fetch_fault, mem_req, mem_addr); end
    step();
    mem_ack = 1'b1; mem_rdata = 32'h66666666;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    tests++; if (instr_valid !== 1'b1 || instr_pc !== 32'h00400020 || fetch_fault !== 1'b0) begin fails++; $display("FAIL mis_push: got v=%b @%h fault=%b want 1 @00400020 0", instr_valid, instr_pc, fetch_fault); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_queue_full();
    test_flush_wait();
    test_flush_ack_pop();
    test_reset_mid_wait();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
- REQ-001 SHALL have parameter DEPTH, default 2, fetch-queue entries (power of two, >=2).
- REQ-002 SHALL have parameter RESET_PC, default 32'h00400020, fetch address expected after reset.
- REQ-003 SHALL have port clk  in  1  single clock; all state changes on posedge.
- REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset).
- REQ-005 SHALL have port pc  in  32  current fetch address from the PC register.
- REQ-006 SHALL have port en_inst_mem  in  1  fetch permitted when 1.
- REQ-007 SHALL have port pc_en  out  1  advance strobe to the PC register's en input.
- REQ-008 SHALL have port flush  in  1  redirect (branch/jump taken); discard all fetched/in-flight words.
- REQ-009 SHALL have ports mem_req out 1, mem_addr out 32, mem_ack in 1, mem_rdata in 32 (instruction-memory handshake).
- REQ-010 SHALL have ports instr out 32, instr_pc out 32, instr_valid out 1, id_ready in 1 (decode-side handshake).
- REQ-011 SHALL have port fetch_fault  out  1  misaligned-fetch indication (see Configuration).

Function
- REQ-012 SHALL implement FSM IDLE -> WAIT on request launch; WAIT -> IDLE on mem_ack; at most one request outstanding.
- REQ-013 SHALL launch in IDLE only when en_inst_mem=1, flush=0 and registered queue count < DEPTH; launch registers mem_addr=pc and sets mem_req=1 next cycle.
- REQ-014 SHALL hold mem_req=1 and mem_addr stable in WAIT until the cycle mem_ack=1, including across flush.
- REQ-015 SHALL accept mem_ack only while mem_req=1; mem_ack while mem_req=0 SHALL be ignored.
- REQ-016 SHALL on mem_ack (no discard pending, no flush) push {mem_rdata, mem_addr} into the queue and assert pc_en for that one cycle.
- REQ-017 SHALL present queue head on instr/instr_pc with instr_valid=1 whenever queue non-empty; pop on instr_valid&&id_ready.
- REQ-018 SHALL give latency of one cycle from the mem_ack edge to instr_valid when queue was empty.
- REQ-019 SHALL free a slot for launch only from the cycle after a pop (no same-cycle pop-to-launch bypass); overflow SHALL be impossible.
- REQ-020 SHALL on flush=1: empty queue at next edge, assert pc_en that cycle, and if in WAIT set a discard flag so the pending response is dropped without push or pc_en.
- REQ-021 SHALL when flush and mem_ack coincide drop the response, assert pc_en once, and clear the discard flag.
- REQ-022 SHALL when flush and pop coincide let flush win (queue empty, no double decrement).
- REQ-023 SHALL keep pc_en=0 in all cycles not covered by REQ-016/REQ-020, so the PC holds while memory stalls.
- REQ-024 SHALL when en_inst_mem drops in WAIT complete the outstanding request normally and launch no new one.
- REQ-025 SHALL use wrap-around read/write pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits.

Reset
- REQ-026 SHALL while reset=0 force: FSM=IDLE, queue empty, discard=0, mem_req=0, mem_addr=RESET_PC, pc_en=0, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0.
- REQ-027 SHALL when reset asserts mid-request abandon it immediately (mem_req=0 asynchronously); a later mem_ack SHALL be ignored.
- REQ-028 SHALL launch the first request no earlier than the first posedge after reset deasserts.

Configuration
- REQ-029 SHALL honour macro FETCH_MISALIGN_TRAP_EN: defined -> launch with pc[1:0]!=0 instead enters FAULT, sets fetch_fault=1, issues no request, pc_en=0; only flush or reset leaves FAULT (to IDLE, fault cleared).
- REQ-030 SHALL without FETCH_MISALIGN_TRAP_EN force mem_addr[1:0]=2'b00, tie fetch_fault=0 and have no FAULT state.

Verification
- REQ-031 Reset release, pc=32'h00400020, mem_ack one cycle after mem_req, rdata=32'h20080005, id_ready=1 -> mem_addr=32'h00400020, one pc_en pulse, instr_valid next cycle with instr=32'h20080005, instr_pc=32'h00400020.
- REQ-032 id_ready=0, memory acks every request -> exactly DEPTH (2) pushes, 2 pc_en pulses, mem_req stays 0 until id_ready=1 pops an entry.
- REQ-033 flush during WAIT for 32'h00400024, ack 3 cycles later -> that word never appears on instr, pc_en high in flush cycle only, next mem_addr = new pc 32'h00400100.
- REQ-034 flush coincident with mem_ack and pop with 1 entry queued -> queue empty, instr_valid=0 next cycle, exactly one pc_en pulse.
- REQ-035 reset=0 asserted mid-WAIT, mem_ack arrives after release -> mem_req=0 immediately, late ack ignored, no push.
- REQ-036 FETCH_MISALIGN_TRAP_EN defined, pc=32'h00400022 -> fetch_fault=1, mem_req=0; flush clears fault; undefined -> mem_addr=32'h00400020.
